// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the FIFO scoreboard checker.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } chk_state_e;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_occ_model.sv
// Shadow FIFO occupancy and the status/handshake flags the DUT is expected to show.
module fifo_occ_model
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int OCC_W = occ_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [OCC_W-1:0] occ,
  output logic             rd_vld_p1,
  output logic [6:0]       exp_flags
);

  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] AFULL_V = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] ONE_V   = OCC_W'(1);

  logic rd_acc;
  logic wr_exp;
  logic wr_ack_p1;
  logic ovf_p1;
  logic udf_p1;

  assign rd_acc = rd_en && (occ != '0);
  assign wr_exp = wr_en && (occ != DEPTH_V);

  // Order: empty, full, almostempty, almostfull, wr_ack, overflow, underflow
  assign exp_flags = {occ == '0, occ == DEPTH_V, occ == ONE_V, occ == AFULL_V,
                      wr_ack_p1, ovf_p1, udf_p1};

  // Stage p0 -> p1: handshake expectations and read-data valid for next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      rd_vld_p1 <= 1'b0;
      wr_ack_p1 <= 1'b0;
      ovf_p1    <= 1'b0;
      udf_p1    <= 1'b0;
    end else begin
      rd_vld_p1 <= en && rd_acc;
      wr_ack_p1 <= en && wr_exp;
      ovf_p1    <= en && wr_en && !wr_exp;
      udf_p1    <= en && rd_en && !rd_acc;
      if (en) begin
        if (wr_exp && !rd_acc) begin
          occ <= occ + 1'b1;
        end else if (rd_acc && !wr_exp) begin
          occ <= occ - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_checker.sv
// Scoreboard behind the FIFO monitor: checks read data and flags, counts results, captures first error.
module fifo_checker
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0,
  localparam int OCC_W = occ_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic [FIFO_WIDTH-1:0] data_out_golden,
  input  logic                  full,
  input  logic                  almostfull,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  wr_ack,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      data_err_cnt,
  output logic [CNT_W-1:0]      flag_err_cnt,
  output logic [OCC_W-1:0]      occ,
  output logic                  first_err_valid,
  output logic [CNT_W-1:0]      first_err_cycle,
  output logic [FIFO_WIDTH-1:0] first_err_got,
  output logic [FIFO_WIDTH-1:0] first_err_exp
);

  typedef struct packed {
    logic [CNT_W-1:0]      cycle;
    logic [FIFO_WIDTH-1:0] got;
    logic [FIFO_WIDTH-1:0] exp;
  } first_err_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  chk_state_e state;
  chk_state_e state_nxt;
  first_err_t first_err;
  logic [CNT_W-1:0] cyc_cnt;
  logic [6:0] exp_flags;
  logic [6:0] obs_flags;
  logic run;
  logic count;
  logic rd_vld_p1;
  logic data_err;
  logic flag_err;
  logic err_evt;

  fifo_occ_model #(.FIFO_DEPTH(FIFO_DEPTH)) u_occ (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .occ       (occ),
    .rd_vld_p1 (rd_vld_p1),
    .exp_flags (exp_flags)
  );

  assign run       = (state == RUN);
  assign count     = run && !clear;
  assign obs_flags = {empty, full, almostempty, almostfull, wr_ack, overflow, underflow};
  assign data_err  = rd_vld_p1 && (data_out != data_out_golden);
  assign flag_err  = (obs_flags != exp_flags);
  assign err_evt   = count && (data_err || flag_err);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clear && start) state_nxt = RUN;
      RUN:     if (STOP_ON_ERR && err_evt) state_nxt = HALT;
      HALT:    if (clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: compare results land in counters and first-error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      pass_cnt        <= '0;
      data_err_cnt    <= '0;
      flag_err_cnt    <= '0;
      first_err_valid <= 1'b0;
      first_err       <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        cyc_cnt         <= '0;
        pass_cnt        <= '0;
        data_err_cnt    <= '0;
        flag_err_cnt    <= '0;
        first_err_valid <= 1'b0;
        first_err       <= '0;
      end else if (run) begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (rd_vld_p1 && !data_err) pass_cnt <= sat_inc(pass_cnt);
        if (data_err) data_err_cnt <= sat_inc(data_err_cnt);
        if (flag_err) flag_err_cnt <= sat_inc(flag_err_cnt);
        if (err_evt && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err.cycle <= cyc_cnt;
          first_err.got   <= data_err ? data_out : '0;
          first_err.exp   <= data_err ? data_out_golden : '0;
        end
      end
    end
  end

  assign state_o         = state;
  assign first_err_cycle = first_err.cycle;
  assign first_err_got   = first_err.got;
  assign first_err_exp   = first_err.exp;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench for fifo_checker: one instance free-running, one with STOP_ON_ERR=1.
module tb_fifo_checker;

  logic clk = 1'b0;
  logic rst, start, clear, wr_en, rd_en;
  logic [15:0] data_out, data_out_golden;
  logic full, almostfull, empty, almostempty, overflow, underflow, wr_ack;

  logic [1:0]  a_state, b_state;
  logic [15:0] a_pass, a_derr, a_ferr, a_fcyc, a_fgot, a_fexp;
  logic [15:0] b_pass, b_derr, b_ferr, b_fcyc, b_fgot, b_fexp;
  logic [3:0]  a_occ, b_occ;
  logic        a_fval, b_fval;

  int checks = 0;
  int errors = 0;
  int m_occ;
  logic m_wack, m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_checker #(.STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .data_out_golden(data_out_golden), .full(full),
    .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
    .overflow(overflow), .underflow(underflow), .wr_ack(wr_ack),
    .state_o(a_state), .pass_cnt(a_pass), .data_err_cnt(a_derr), .flag_err_cnt(a_ferr),
    .occ(a_occ), .first_err_valid(a_fval), .first_err_cycle(a_fcyc),
    .first_err_got(a_fgot), .first_err_exp(a_fexp)
  );

  fifo_checker #(.STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .data_out_golden(data_out_golden), .full(full),
    .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
    .overflow(overflow), .underflow(underflow), .wr_ack(wr_ack),
    .state_o(b_state), .pass_cnt(b_pass), .data_err_cnt(b_derr), .flag_err_cnt(b_ferr),
    .occ(b_occ), .first_err_valid(b_fval), .first_err_cycle(b_fcyc),
    .first_err_got(b_fgot), .first_err_exp(b_fexp)
  );

  // One clock of a well-behaved 8-deep FIFO; flip inverts selected flags
  // {empty, full, almostempty, almostfull, wr_ack, overflow, underflow}.
  task automatic step(input logic wr, input logic rd, input logic [15:0] d,
                      input logic [15:0] g, input logic [6:0] flip);
    logic racc, wexp;
    wr_en = wr; rd_en = rd; data_out = d; data_out_golden = g;
    {empty, full, almostempty, almostfull, wr_ack, overflow, underflow} =
      {m_occ == 0, m_occ == 8, m_occ == 1, m_occ == 7, m_wack, m_ovf, m_udf} ^ flip;
    @(posedge clk); #1;
    racc = rd && (m_occ != 0);
    wexp = wr && (m_occ != 8);
    m_wack = wexp; m_ovf = wr && !wexp; m_udf = rd && !racc;
    if (wexp && !racc) m_occ++;
    else if (racc && !wexp) m_occ--;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; data_out = '0; data_out_golden = '0;
    {empty, full, almostempty, almostfull, wr_ack, overflow, underflow} = 7'b1000000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_occ = 0; m_wack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'h0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", a_state); end
    checks++; if (a_pass !== 16'd0) begin errors++; $display("FAIL reset_pass got %0d exp 0", a_pass); end
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL reset_derr got %0d exp 0", a_derr); end
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL reset_ferr got %0d exp 0", a_ferr); end
    checks++; if (a_occ !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", a_occ); end
    checks++; if (a_fval !== 1'b0) begin errors++; $display("FAIL reset_fval got %0d exp 0", a_fval); end
    checks++; if (b_state !== 2'd0) begin errors++; $display("FAIL reset_h_state got %0d exp 0", b_state); end
  endtask

  task automatic test_fill();
    do_reset();
    do_start();
    checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", a_state); end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 7'h0);
    checks++; if (a_occ !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d exp 8", a_occ); end
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'h0);
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL fill_ferr got %0d exp 0", a_ferr); end
    checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL fill_state got %0d exp 1", a_state); end
  endtask

  task automatic test_drain();
    logic [15:0] d;
    for (int i = 0; i < 9; i++) begin
      d = 16'(i);
      step(1'b0, i < 8, d, d, 7'h0);
    end
    checks++; if (a_pass !== 16'd8) begin errors++; $display("FAIL drain_pass got %0d exp 8", a_pass); end
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL drain_derr got %0d exp 0", a_derr); end
    checks++; if (a_occ !== 4'd0) begin errors++; $display("FAIL drain_occ got %0d exp 0", a_occ); end
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'h0);
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL drain_ferr got %0d exp 0", a_ferr); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_start();
    step(1'b0, 1'b1, 16'h0, 16'h0, 7'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'h0);
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL udf_ok_ferr got %0d exp 0", a_ferr); end
    checks++; if (a_pass !== 16'd0) begin errors++; $display("FAIL udf_ok_pass got %0d exp 0", a_pass); end
    checks++; if (a_fval !== 1'b0) begin errors++; $display("FAIL udf_ok_fval got %0d exp 0", a_fval); end
    step(1'b0, 1'b1, 16'h0, 16'h0, 7'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'b0000001);
    checks++; if (a_ferr !== 16'd1) begin errors++; $display("FAIL udf_bad_ferr got %0d exp 1", a_ferr); end
    checks++; if (a_fval !== 1'b1) begin errors++; $display("FAIL udf_bad_fval got %0d exp 1", a_fval); end
    checks++; if (a_fgot !== 16'h0) begin errors++; $display("FAIL udf_bad_fgot got %0h exp 0", a_fgot); end
    checks++; if (a_fcyc !== 16'd3) begin errors++; $display("FAIL udf_bad_fcyc got %0d exp 3", a_fcyc); end
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL udf_bad_derr got %0d exp 0", a_derr); end
    checks++; if (b_state !== 2'd2) begin errors++; $display("FAIL udf_h_state got %0d exp 2", b_state); end
  endtask

  task automatic test_halt();
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 7'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 7'h0);
    step(1'b0, 1'b1, 16'h1, 16'h1, 7'h0);
    step(1'b0, 1'b1, 16'h2, 16'h2, 7'h0);
    step(1'b0, 1'b0, 16'hBEEF, 16'h0003, 7'h0);
    checks++; if (b_derr !== 16'd1) begin errors++; $display("FAIL halt_derr got %0d exp 1", b_derr); end
    checks++; if (b_pass !== 16'd2) begin errors++; $display("FAIL halt_pass got %0d exp 2", b_pass); end
    checks++; if (b_fgot !== 16'hBEEF) begin errors++; $display("FAIL halt_fgot got %0h exp beef", b_fgot); end
    checks++; if (b_fexp !== 16'h0003) begin errors++; $display("FAIL halt_fexp got %0h exp 3", b_fexp); end
    checks++; if (b_fcyc !== 16'd6) begin errors++; $display("FAIL halt_fcyc got %0d exp 6", b_fcyc); end
    checks++; if (b_state !== 2'd2) begin errors++; $display("FAIL halt_state got %0d exp 2", b_state); end
    checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL nohalt_state got %0d exp 1", a_state); end
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 7'h7F);
    checks++; if (b_ferr !== 16'd0) begin errors++; $display("FAIL halt_frozen_ferr got %0d exp 0", b_ferr); end
    checks++; if (b_occ !== 4'd0) begin errors++; $display("FAIL halt_frozen_occ got %0d exp 0", b_occ); end
    clear = 1'b1;
    step(1'b0, 1'b0, 16'h0, 16'h0, 7'h0);
    clear = 1'b0;
    checks++; if (b_state !== 2'd0) begin errors++; $display("FAIL clear_h_state got %0d exp 0", b_state); end
    checks++; if (b_derr !== 16'd0) begin errors++; $display("FAIL clear_h_derr got %0d exp 0", b_derr); end
    checks++; if (b_fval !== 1'b0) begin errors++; $display("FAIL clear_h_fval got %0d exp 0", b_fval); end
    checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL clear_run_state got %0d exp 1", a_state); end
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL clear_run_derr got %0d exp 0", a_derr); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) begin
      d = (i >= 5) ? 16'(i - 4) : 16'h0;
      step(i < 9, (i >= 4) && (i < 9), d, d, 7'h0);
      if (i == 6) begin
        checks++; if (a_occ !== 4'd4) begin errors++; $display("FAIL b2b_mid_occ got %0d exp 4", a_occ); end
      end
    end
    checks++; if (a_occ !== 4'd4) begin errors++; $display("FAIL b2b_occ got %0d exp 4", a_occ); end
    checks++; if (a_pass !== 16'd5) begin errors++; $display("FAIL b2b_pass got %0d exp 5", a_pass); end
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", a_ferr); end
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL b2b_derr got %0d exp 0", a_derr); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h0, 16'h0, (i == 2) ? 7'b0000100 : 7'h0);
    step(1'b0, 1'b1, 16'h0, 16'h0, 7'h0);
    step(1'b0, 1'b1, 16'h1, 16'h1, 7'h0);
    checks++; if (a_occ !== 4'd5) begin errors++; $display("FAIL mid_pre_occ got %0d exp 5", a_occ); end
    checks++; if (a_pass !== 16'd1) begin errors++; $display("FAIL mid_pre_pass got %0d exp 1", a_pass); end
    checks++; if (a_ferr !== 16'd1) begin errors++; $display("FAIL mid_pre_ferr got %0d exp 1", a_ferr); end
    rst = 1'b1; rd_en = 1'b0; data_out = 16'hBEEF; data_out_golden = 16'h0002;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", a_state); end
    checks++; if (a_occ !== 4'd0) begin errors++; $display("FAIL mid_occ got %0d exp 0", a_occ); end
    checks++; if (a_pass !== 16'd0) begin errors++; $display("FAIL mid_pass got %0d exp 0", a_pass); end
    checks++; if (a_ferr !== 16'd0) begin errors++; $display("FAIL mid_ferr got %0d exp 0", a_ferr); end
    checks++; if (a_fval !== 1'b0) begin errors++; $display("FAIL mid_fval got %0d exp 0", a_fval); end
    checks++; if (a_fcyc !== 16'd0) begin errors++; $display("FAIL mid_fcyc got %0d exp 0", a_fcyc); end
    @(posedge clk); #1;
    checks++; if (a_derr !== 16'd0) begin errors++; $display("FAIL mid_pending_derr got %0d exp 0", a_derr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_halt();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/fifo_checker.md
Name: fifo_checker

Overview:
- Synthesizable scoreboard directly downstream of the FIFO monitor.
- Consumes the same sampled FIFO interface signals the monitor prints: data_out, data_out_golden, the control inputs and the status flags.
- Keeps a shadow occupancy model and compares data and flags on every qualified cycle.
- Accumulates pass/error counts and captures the first mismatch for the bench to read back.

Parameters:
FIFO_WIDTH, 16, width of data_out / data_out_golden
FIFO_DEPTH, 8, FIFO capacity in words (power of two, >=4)
CNT_W, 16, width of all statistic counters
STOP_ON_ERR, 0, 1 = freeze checking on first error (HALT state)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; IDLE->RUN
clear  in  1  pulse; zero counters and capture regs, stay in current state (HALT->IDLE)
wr_en  in  1  FIFO write request
rd_en  in  1  FIFO read request
data_out  in  FIFO_WIDTH  DUT read data
data_out_golden  in  FIFO_WIDTH  reference-model read data
full, almostfull, empty, almostempty  in  1 each  DUT status flags
overflow, underflow, wr_ack  in  1 each  DUT handshake flags
state_o  out  2  00 IDLE, 01 RUN, 10 HALT
pass_cnt  out  CNT_W  data compares that matched
data_err_cnt  out  CNT_W  data compares that mismatched
flag_err_cnt  out  CNT_W  cycles with any flag mismatch
occ  out  $clog2(FIFO_DEPTH)+1  shadow occupancy
first_err_valid  out  1  sticky; first error captured
first_err_cycle  out  CNT_W  cycle index of first error
first_err_got  out  FIFO_WIDTH  DUT data at first data error (0 if flag error)
first_err_exp  out  FIFO_WIDTH  golden data at first data error

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE, all counters/occ/capture regs 0, first_err_valid 0, internal pipeline regs 0.
- FSM:
  - IDLE->RUN on start.
  - RUN->HALT on first error when STOP_ON_ERR=1.
  - HALT->IDLE on clear.
  - start in RUN/HALT is ignored.
  - clear has priority over start in the same cycle.
- Checking happens only in RUN. cyc_cnt (internal, CNT_W) increments every RUN cycle, wraps at 2^CNT_W.
- Expected values from the previous cycle's registered state:
  - rd_acc = rd_en & (occ != 0)
  - wr_exp = wr_en & (occ != FIFO_DEPTH)
- Cycle after a RUN cycle with rd_acc=1 (1-cycle read latency):
  - compare data_out vs data_out_golden.
  - Equal: pass_cnt++. Unequal: data_err_cnt++.
- Flag compare every RUN cycle against the current occ:
  - empty==(occ==0); full==(occ==FIFO_DEPTH)
  - almostempty==(occ==1); almostfull==(occ==FIFO_DEPTH-1)
  - wr_ack==prev wr_exp; overflow==prev(wr_en & !wr_exp); underflow==prev(rd_en & !rd_acc)
  - Any mismatch: flag_err_cnt++ (once per cycle).
- occ update:
  - +1 on wr_exp & !rd_acc; -1 on rd_acc & !wr_exp.
  - Unchanged when both are set, including simultaneous read/write while full or empty per the guards above.
  - Never exceeds FIFO_DEPTH, never goes below 0.
- First error: on the first cycle with a data or flag error while first_err_valid=0, latch cycle/got/exp and set first_err_valid. Later errors do not overwrite.
- Data error and flag error in the same cycle: both counters increment. Capture records data values.
- Counters saturate at all-ones; they do not wrap.
- Reset mid-RUN: everything returns to reset values in one cycle. In-flight read compare is discarded.
- HALT: counters and occ frozen; inputs ignored.

Decomposition:
- Shared package fifo_chk_pkg:
  - typedef enum logic [1:0] chk_state_e {IDLE, RUN, HALT}
  - localparam occ width function
  - struct first_err_t {cycle, got, exp}
- One natural sub-module: fifo_occ_model (shadow occupancy + expected-flag generation). The top keeps the FSM, compare and counters.

Test Plan:
1. rst=1 for 2 cycles, then start; 8 writes (wr_en=1), DUT flags correct -> occ=8, full expected, flag_err_cnt=0, state RUN.
2. Continue with 8 reads, data_out==golden (0x0001..0x0008) -> pass_cnt=8, data_err_cnt=0, occ=0, empty expected.
3. Read at occ=0 with DUT underflow=1 the next cycle -> flag_err_cnt=0. Same stimulus with underflow=0 -> flag_err_cnt=1, first_err_valid=1, first_err_got=0.
4. STOP_ON_ERR=1, 3rd read returns data_out=0xBEEF vs golden 0x0003 -> data_err_cnt=1, first_err_got=0xBEEF, first_err_exp=0x0003, state HALT, pass_cnt stays 2.
5. Simultaneous wr_en=rd_en=1 at occ=4 for 5 cycles -> occ stays 4, pass_cnt+=5, wr_ack expected every cycle.
6. rst asserted mid-RUN with occ=5 and counters nonzero -> next cycle all outputs 0, state IDLE; the pending read compare is not counted.
